// File: rtl/alien_swarm.sv
// Alien formation: N_ROWS x N_COLS enemies marching together. Tracks the alive mask,
// resolves one bullet kill per frame, moves/drops the formation on fsync and drives
// the enemy pixel layer combinationally.
module alien_swarm #(
  parameter int unsigned N_COLS        = 8,
  parameter int unsigned N_ROWS        = 4,
  parameter int unsigned ALIEN_W       = 24,
  parameter int unsigned ALIEN_H       = 16,
  parameter int unsigned PITCH_X       = 32,
  parameter int unsigned PITCH_Y       = 24,
  parameter int unsigned START_X       = 64,
  parameter int unsigned START_Y       = 48,
  parameter int unsigned SPEED         = 2,
  parameter int unsigned SPEEDUP_SHIFT = 3,
  parameter int unsigned DROP          = 8,
  parameter int unsigned HRES          = 640,
  parameter int unsigned LAND_Y        = 440,
  parameter logic [23:0] COLOR         = 24'h00FF00,
  localparam int unsigned NUM_ALIENS   = N_ROWS * N_COLS,
  localparam int unsigned IDX_W        = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1,
  localparam int unsigned CNT_W        = $clog2(NUM_ALIENS + 1)
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    fsync,
  input  logic                    wave_restart,
  input  logic signed [11:0]      hpos,
  input  logic signed [11:0]      vpos,
  input  logic signed [11:0]      bullet_x,
  input  logic signed [11:0]      bullet_y,
  input  logic                    bullet_active,
  output logic [7:0]              pixel [0:2],
  output logic                    active,
  output logic                    hit,
  output logic [IDX_W-1:0]        hit_index,
  output logic [NUM_ALIENS-1:0]   alive_mask,
  output logic [CNT_W-1:0]        alive_count,
  output logic                    all_dead,
  output logic                    landed
);

  localparam logic signed [11:0] ALIEN_W_S = 12'(ALIEN_W);
  localparam logic signed [11:0] ALIEN_H_S = 12'(ALIEN_H);
  localparam logic signed [11:0] START_X_S = 12'(START_X);
  localparam logic signed [11:0] START_Y_S = 12'(START_Y);
  localparam logic signed [11:0] SPEED_S   = 12'(SPEED);
  localparam logic signed [11:0] DROP_S    = 12'(DROP);
  localparam logic signed [11:0] HRES_S    = 12'(HRES);
  localparam logic signed [11:0] LAND_S    = 12'(LAND_Y);

  logic signed [11:0]    ox_q, ox_d, oy_q, oy_d;
  logic                  move_left_q, move_left_d;
  logic [NUM_ALIENS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  hit_q, hit_d;
  logic [IDX_W-1:0]      hit_index_q, hit_index_d;
  logic                  landed_q, landed_d;

  logic signed [11:0]    col_x [N_COLS];
  logic signed [11:0]    row_y [N_ROWS];
  logic [N_COLS-1:0]     col_live, pix_col, bul_col;
  logic [N_ROWS-1:0]     row_live, pix_row, bul_row;
  logic [NUM_ALIENS-1:0] pix_sel, bul_sel;

  logic                  kill;
  logic [IDX_W-1:0]      kill_idx;
  logic [CNT_W-1:0]      killed;
  logic signed [11:0]    step, left_x, right_x, bottom_y;
  logic                  dead_now, land_now;

  // Per-column geometry, liveness and comparators for the beam and the bullet.
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [N_ROWS-1:0] col_bits;
    for (genvar r = 0; r < N_ROWS; r++) begin : g_bit
      assign col_bits[r] = mask_q[r*N_COLS + c];
    end
    assign col_x[c]    = ox_q + 12'(c * PITCH_X);
    assign col_live[c] = |col_bits;
    assign pix_col[c]  = (hpos >= col_x[c]) && (hpos <= col_x[c] + ALIEN_W_S);
    assign bul_col[c]  = (bullet_x >= col_x[c]) && (bullet_x <= col_x[c] + ALIEN_W_S);
  end

  // Per-row geometry, liveness and comparators.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    assign row_y[r]    = oy_q + 12'(r * PITCH_Y);
    assign row_live[r] = |mask_q[r*N_COLS +: N_COLS];
    assign pix_row[r]  = (vpos >= row_y[r]) && (vpos <= row_y[r] + ALIEN_H_S);
    assign bul_row[r]  = (bullet_y >= row_y[r]) && (bullet_y <= row_y[r] + ALIEN_H_S);
  end

  // Cross row and column matches into per-alien selects.
  for (genvar i = 0; i < NUM_ALIENS; i++) begin : g_sel
    assign pix_sel[i] = pix_col[i % N_COLS] && pix_row[i / N_COLS];
    assign bul_sel[i] = bul_col[i % N_COLS] && bul_row[i / N_COLS];
  end

  // Lowest-index live alien under the bullet; scanned downward so the lowest wins.
  always_comb begin
    kill     = 1'b0;
    kill_idx = '0;
    for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
      if (bullet_active && bul_sel[i] && mask_q[i]) begin
        kill     = 1'b1;
        kill_idx = IDX_W'(i);
      end
    end
  end

  // Formation extents from the outermost surviving columns and the lowest live row.
  always_comb begin
    right_x  = ox_q + ALIEN_W_S;
    left_x   = ox_q;
    bottom_y = oy_q + ALIEN_H_S;
    for (int c = 0; c < N_COLS; c++) begin
      if (col_live[c]) right_x = col_x[c] + ALIEN_W_S;
    end
    for (int c = N_COLS - 1; c >= 0; c--) begin
      if (col_live[c]) left_x = col_x[c];
    end
    for (int r = 0; r < N_ROWS; r++) begin
      if (row_live[r]) bottom_y = row_y[r] + ALIEN_H_S;
    end
  end

  assign killed   = CNT_W'(NUM_ALIENS) - count_q;
  assign step     = SPEED_S + 12'(killed >> SPEEDUP_SHIFT);
  assign dead_now = (count_q == '0);
  // Landing freezes the formation from the very frame it is detected.
  assign land_now = !landed_q && !dead_now && (bottom_y >= LAND_S);

  // Next-state: restart beats fsync; a kill and a move may share one frame.
  always_comb begin
    ox_d        = ox_q;
    oy_d        = oy_q;
    move_left_d = move_left_q;
    mask_d      = mask_q;
    count_d     = count_q;
    hit_d       = 1'b0;
    hit_index_d = hit_index_q;
    landed_d    = landed_q;
    if (wave_restart) begin
      ox_d        = START_X_S;
      oy_d        = START_Y_S;
      move_left_d = 1'b0;
      mask_d      = '1;
      count_d     = CNT_W'(NUM_ALIENS);
      landed_d    = 1'b0;
    end else if (fsync) begin
      if (kill) begin
        mask_d[kill_idx] = 1'b0;
        count_d          = count_q - CNT_W'(1);
        hit_d            = 1'b1;
        hit_index_d      = kill_idx;
      end
      if (land_now) begin
        landed_d = 1'b1;
      end else if (!landed_q && !dead_now) begin
        if (!move_left_q) begin
          if (right_x + step < HRES_S) begin
            ox_d = ox_q + step;
          end else begin
            move_left_d = 1'b1;
            oy_d        = oy_q + DROP_S;
          end
        end else begin
          if (left_x - step > 12'sd0) begin
            ox_d = ox_q - step;
          end else begin
            move_left_d = 1'b0;
            oy_d        = oy_q + DROP_S;
          end
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      ox_q        <= START_X_S;
      oy_q        <= START_Y_S;
      move_left_q <= 1'b0;
      mask_q      <= '1;
      count_q     <= CNT_W'(NUM_ALIENS);
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      landed_q    <= 1'b0;
    end else begin
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      move_left_q <= move_left_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      hit_index_q <= hit_index_d;
      landed_q    <= landed_d;
    end
  end

  // Outputs and zero-latency render layer (B, G, R order).
  always_comb begin
    active      = |(mask_q & pix_sel);
    pixel[0]    = active ? COLOR[7:0]   : 8'h00;
    pixel[1]    = active ? COLOR[15:8]  : 8'h00;
    pixel[2]    = active ? COLOR[23:16] : 8'h00;
    hit         = hit_q;
    hit_index   = hit_index_q;
    alive_mask  = mask_q;
    alive_count = count_q;
    all_dead    = dead_now;
    landed      = landed_q;
  end

endmodule

// File: tb/tb_alien_swarm.sv
// Directed self-checking bench for alien_swarm with default parameters.
module tb_alien_swarm;

  logic              pixel_clk = 1'b0;
  logic              rst = 1'b1;
  logic              fsync = 1'b0;
  logic              wave_restart = 1'b0;
  logic signed [11:0] hpos = '0, vpos = '0, bullet_x = '0, bullet_y = '0;
  logic              bullet_active = 1'b0;
  logic [7:0]        pixel [0:2];
  logic              active, hit, all_dead, landed;
  logic [4:0]        hit_index;
  logic [31:0]       alive_mask;
  logic [5:0]        alive_count;

  int n_cmp = 0;
  int n_err = 0;

  alien_swarm dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .fsync         (fsync),
    .wave_restart  (wave_restart),
    .hpos          (hpos),
    .vpos          (vpos),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .pixel         (pixel),
    .active        (active),
    .hit           (hit),
    .hit_index     (hit_index),
    .alive_mask    (alive_mask),
    .alive_count   (alive_count),
    .all_dead      (all_dead),
    .landed        (landed)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One idle cycle then a one-cycle fsync; returns at the negedge after its edge.
  task automatic frame();
    @(negedge pixel_clk);
    fsync = 1'b1;
    @(negedge pixel_clk);
    fsync = 1'b0;
  endtask

  task automatic restart();
    @(negedge pixel_clk);
    wave_restart = 1'b1;
    @(negedge pixel_clk);
    wave_restart = 1'b0;
  endtask

  task automatic shoot(input int x, input int y);
    bullet_x      = 12'(x);
    bullet_y      = 12'(y);
    bullet_active = 1'b1;
  endtask

  int ox_m;
  int frames;

  initial begin
    repeat (3) @(negedge pixel_clk);
    rst = 1'b0;
    @(negedge pixel_clk);

    // Reset state
    check("rst_ox", 32'(dut.ox_q), 64);
    check("rst_oy", 32'(dut.oy_q), 48);
    check("rst_count", 32'(alive_count), 32);
    check("rst_mask", alive_mask, 32'hFFFF_FFFF);
    check("rst_hit", 32'(hit), 0);
    check("rst_idx", 32'(hit_index), 0);
    check("rst_landed", 32'(landed), 0);
    check("rst_dead", 32'(all_dead), 0);

    // Render boundaries around alien (0,0) at x 64..88, y 48..64
    hpos = 12'd84; vpos = 12'd48; #1;
    check("pix_in", 32'(active), 1);
    check("pix_g", 32'(pixel[1]), 32'hFF);
    check("pix_r", 32'(pixel[2]), 0);
    hpos = 12'd88; #1; check("pix_right_edge", 32'(active), 1);
    hpos = 12'd89; #1; check("pix_gap_lo", 32'(active), 0);
    hpos = 12'd92; #1; check("pix_gap", 32'(active), 0);
    check("pix_gap_g", 32'(pixel[1]), 0);
    hpos = 12'd64; vpos = 12'd64; #1; check("pix_bottom_edge", 32'(active), 1);
    vpos = 12'd65; #1; check("pix_below", 32'(active), 0);

    // Ten frames, no bullet
    repeat (10) frame();
    check("march_ox", 32'(dut.ox_q), 84);
    check("march_oy", 32'(dut.oy_q), 48);

    // Kill alien (0,0) at its centre
    shoot(96, 56);
    frame();
    check("kill0_hit", 32'(hit), 1);
    check("kill0_idx", 32'(hit_index), 0);
    check("kill0_mask", 32'(alive_mask[0]), 0);
    check("kill0_count", 32'(alive_count), 31);
    check("kill0_ox", 32'(dut.ox_q), 86);
    @(negedge pixel_clk);
    check("kill0_pulse", 32'(hit), 0);
    frame();
    check("rekill_hit", 32'(hit), 0);
    check("rekill_count", 32'(alive_count), 31);
    check("rekill_ox", 32'(dut.ox_q), 88);

    // Inactive bullet over alien (0,1) does nothing, active one kills it
    shoot(130, 56);
    bullet_active = 1'b0;
    frame();
    check("inact_hit", 32'(hit), 0);
    check("inact_mask", 32'(alive_mask[1]), 1);
    check("inact_count", 32'(alive_count), 31);
    bullet_active = 1'b1;
    frame();
    check("kill1_hit", 32'(hit), 1);
    check("kill1_idx", 32'(hit_index), 1);
    check("kill1_count", 32'(alive_count), 30);
    check("kill1_ox", 32'(dut.ox_q), 92);
    bullet_active = 1'b0;

    // Restart reloads everything but hit_index
    restart();
    check("rs_ox", 32'(dut.ox_q), 64);
    check("rs_oy", 32'(dut.oy_q), 48);
    check("rs_count", 32'(alive_count), 32);
    check("rs_mask", alive_mask, 32'hFFFF_FFFF);
    check("rs_idx", 32'(hit_index), 1);

    // Kill row 3 (8 aliens); step stays 2 during kills, then becomes 3
    for (int k = 0; k < 8; k++) begin
      shoot(76 + 34 * k, 128);
      frame();
    end
    bullet_active = 1'b0;
    check("row3_count", 32'(alive_count), 24);
    check("row3_mask", alive_mask, 32'h00FF_FFFF);
    check("row3_idx", 32'(hit_index), 31);
    check("row3_ox", 32'(dut.ox_q), 80);
    frame();
    check("step3_ox", 32'(dut.ox_q), 83);

    // Right-edge reversal with step 3
    repeat (102) frame();
    check("pre_rev_ox", 32'(dut.ox_q), 389);
    check("pre_rev_oy", 32'(dut.oy_q), 48);
    frame();
    check("rev_ox", 32'(dut.ox_q), 389);
    check("rev_oy", 32'(dut.oy_q), 56);
    frame();
    check("left_ox", 32'(dut.ox_q), 386);
    check("left_oy", 32'(dut.oy_q), 56);

    // Killing column 7 moves the reversal point 32 px right
    restart();
    for (int k = 0; k < 4; k++) begin
      shoot(300 + 2 * k, 56 + 24 * k);
      frame();
    end
    bullet_active = 1'b0;
    check("col7_count", 32'(alive_count), 28);
    check("col7_mask", alive_mask, 32'h7F7F_7F7F);
    check("col7_ox", 32'(dut.ox_q), 72);
    repeat (175) frame();
    check("col7_pre_ox", 32'(dut.ox_q), 422);
    check("col7_pre_oy", 32'(dut.oy_q), 48);
    hpos = 12'd651; vpos = 12'd50; #1; check("col7_dead_pix", 32'(active), 0);
    hpos = 12'd619; #1; check("col6_live_pix", 32'(active), 1);
    frame();
    check("col7_rev_ox", 32'(dut.ox_q), 422);
    check("col7_rev_oy", 32'(dut.oy_q), 56);

    // Kill all 32 in index order, tracking the accelerating march
    restart();
    ox_m = 64;
    for (int i = 0; i < 32; i++) begin
      shoot(ox_m + 32 * (i % 8) + 12, 56 + 24 * (i / 8));
      frame();
      check("sweep_hit", 32'(hit), 1);
      ox_m = ox_m + 2 + (i >> 3);
    end
    bullet_active = 1'b0;
    check("dead_count", 32'(alive_count), 0);
    check("dead_flag", 32'(all_dead), 1);
    check("dead_mask", alive_mask, 0);
    check("dead_idx", 32'(hit_index), 31);
    check("dead_ox", 32'(dut.ox_q), 176);
    repeat (5) frame();
    check("dead_frozen_ox", 32'(dut.ox_q), 176);
    check("dead_frozen_oy", 32'(dut.oy_q), 48);

    // March a full wave down to the landing line
    restart();
    frames = 0;
    while (!landed && frames < 20000) begin
      frame();
      frames++;
    end
    check("land_frames", frames, 7380);
    check("land_flag", 32'(landed), 1);
    check("land_ox", 32'(dut.ox_q), 2);
    check("land_oy", 32'(dut.oy_q), 352);
    shoot(46, 360);
    frame();
    bullet_active = 1'b0;
    check("land_hit", 32'(hit), 1);
    check("land_idx", 32'(hit_index), 1);
    check("land_count", 32'(alive_count), 31);
    repeat (3) frame();
    check("land_frozen_ox", 32'(dut.ox_q), 2);
    check("land_frozen_oy", 32'(dut.oy_q), 352);
    check("land_sticky", 32'(landed), 1);

    // Restart coincident with fsync while a bullet sits on a live alien
    shoot(14, 360);
    @(negedge pixel_clk);
    wave_restart = 1'b1;
    fsync        = 1'b1;
    @(negedge pixel_clk);
    wave_restart = 1'b0;
    fsync        = 1'b0;
    bullet_active = 1'b0;
    check("rsf_hit", 32'(hit), 0);
    check("rsf_ox", 32'(dut.ox_q), 64);
    check("rsf_oy", 32'(dut.oy_q), 48);
    check("rsf_mask", alive_mask, 32'hFFFF_FFFF);
    check("rsf_count", 32'(alive_count), 32);
    check("rsf_landed", 32'(landed), 0);
    check("rsf_idx", 32'(hit_index), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
